// File: rtl/async_fifo_1clk.sv
// Single-clock Gray-pointer FIFO with two-flop pointer synchronizers, timed like the dual-clock variant.
// Define ASYNC_FIFO_LEVEL_EN to drive w_level/r_level; otherwise both levels are tied to zero.
module async_fifo_1clk #(
  parameter int WI  = 16,
  parameter int L2D = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [WI-1:0] w_data,
  input  logic          w_strobe,
  output logic          w_full,
  output logic [L2D:0]  w_level,
  output logic [WI-1:0] r_data,
  input  logic          r_strobe,
  output logic          r_empty,
  output logic [L2D:0]  r_level
);

  localparam int D = 1 << L2D;

  logic [WI-1:0] mem [D];
  logic [L2D:0]  wptr, rptr, wptr_inc, rptr_inc;
  logic [L2D:0]  wgray, rgray;
  logic [L2D:0]  wgray_s1, wgray_s2, rgray_s1, rgray_s2;
  logic          w_accept, r_accept;

  function automatic logic [L2D:0] bin2gray(input logic [L2D:0] b);
    return b ^ (b >> 1);
  endfunction

  assign w_accept = w_strobe & ~w_full;
  assign r_accept = r_strobe & ~r_empty;
  assign wptr_inc = wptr + 1'b1;
  assign rptr_inc = rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      wgray <= '0;
    end else if (w_accept) begin
      wptr  <= wptr_inc;
      wgray <= bin2gray(wptr_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      mem[wptr[L2D-1:0]] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      rgray <= '0;
    end else if (r_accept) begin
      rptr  <= rptr_inc;
      rgray <= bin2gray(rptr_inc);
    end
  end

  // Each Gray pointer crosses to the opposite side through two flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgray_s1 <= '0;
      rgray_s2 <= '0;
      wgray_s1 <= '0;
      wgray_s2 <= '0;
    end else begin
      rgray_s1 <= rgray;
      rgray_s2 <= rgray_s1;
      wgray_s1 <= wgray;
      wgray_s2 <= wgray_s1;
    end
  end

  // Full when the Gray pointers differ only in their top two bits (a distance of exactly D).
  assign w_full  = (wgray == {~rgray_s2[L2D:L2D-1], rgray_s2[L2D-2:0]});
  assign r_empty = (rgray == wgray_s2);
  assign r_data  = mem[rptr[L2D-1:0]];

`ifdef ASYNC_FIFO_LEVEL_EN
  function automatic logic [L2D:0] gray2bin(input logic [L2D:0] g);
    logic [L2D:0] b;
    b[L2D] = g[L2D];
    for (int i = L2D - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [L2D:0] rptr_w, wptr_r;

  assign rptr_w  = gray2bin(rgray_s2);
  assign wptr_r  = gray2bin(wgray_s2);
  assign w_level = wptr - rptr_w;
  assign r_level = wptr_r - rptr;
`else
  assign w_level = '0;
  assign r_level = '0;
`endif

endmodule

// File: tb/tb_async_fifo_1clk.sv
// Self-checking bench for async_fifo_1clk using a per-cycle count/queue reference model.
// Level expectations follow ASYNC_FIFO_LEVEL_EN the same way the design does.
module tb_async_fifo_1clk;

  localparam int WI  = 16;
  localparam int L2D = 4;
  localparam int D   = 1 << L2D;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WI-1:0] w_data = '0;
  logic          w_strobe = 1'b0;
  logic          r_strobe = 1'b0;
  logic          w_full, r_empty;
  logic [L2D:0]  w_level, r_level;
  logic [WI-1:0] r_data;

  int checks = 0;
  int errors = 0;

  // Model: total writes/reads after each edge, plus read/write totals from two edges back.
  int nw = 0, nr = 0;
  int nw_p1 = 0, nw_p2 = 0, nr_p1 = 0, nr_p2 = 0;
  logic [WI-1:0] q[$];

  async_fifo_1clk #(.WI(WI), .L2D(L2D)) dut (
    .clk      (clk),
    .reset    (reset),
    .w_data   (w_data),
    .w_strobe (w_strobe),
    .w_full   (w_full),
    .w_level  (w_level),
    .r_data   (r_data),
    .r_strobe (r_strobe),
    .r_empty  (r_empty),
    .r_level  (r_level)
  );

  always #5 clk = ~clk;

  function automatic int m_wl();
    return nw - nr_p2;
  endfunction

  function automatic int m_rl();
    return nw_p2 - nr;
  endfunction

  function automatic logic [L2D:0] exp_lvl(input int v);
`ifdef ASYNC_FIFO_LEVEL_EN
    return (L2D+1)'(v);
`else
    return '0;
`endif
  endfunction

  task automatic step(input logic rst, input logic ws, input logic rs, input logic [WI-1:0] d);
    logic acc_w, acc_r;
    reset    = rst;
    w_strobe = ws;
    r_strobe = rs;
    w_data   = d;
    acc_w = !rst && ws && (m_wl() != D);
    acc_r = !rst && rs && (m_rl() != 0);
    @(posedge clk);
    if (rst) begin
      nw = 0; nr = 0; nw_p1 = 0; nw_p2 = 0; nr_p1 = 0; nr_p2 = 0;
      q.delete();
    end else begin
      nr_p2 = nr_p1; nr_p1 = nr;
      nw_p2 = nw_p1; nw_p1 = nw;
      if (acc_w) begin
        q.push_back(d);
        nw++;
      end
      if (acc_r) begin
        void'(q.pop_front());
        nr++;
      end
    end
    #1;
    reset    = 1'b0;
    w_strobe = 1'b0;
    r_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
    checks++; if (w_level !== exp_lvl(0)) begin errors++; $display("[TB] FAIL reset_wlevel: got %0d expected %0d", w_level, exp_lvl(0)); end
    checks++; if (r_level !== exp_lvl(0)) begin errors++; $display("[TB] FAIL reset_rlevel: got %0d expected %0d", r_level, exp_lvl(0)); end
    checks++; if (w_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_wfull: got %b expected 0", w_full); end
    checks++; if (r_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_rempty: got %b expected 1", r_empty); end
  endtask

  task automatic test_single_write();
    step(1'b0, 1'b1, 1'b0, 16'h1234);
    checks++; if (w_level !== exp_lvl(1)) begin errors++; $display("[TB] FAIL wr_own_wlevel: got %0d expected %0d", w_level, exp_lvl(1)); end
    checks++; if (r_level !== exp_lvl(0)) begin errors++; $display("[TB] FAIL wr_early_rlevel: got %0d expected %0d", r_level, exp_lvl(0)); end
    checks++; if (r_empty !== 1'b1) begin errors++; $display("[TB] FAIL wr_early_rempty: got %b expected 1", r_empty); end
    idle(1);
    checks++; if (r_empty !== 1'b1) begin errors++; $display("[TB] FAIL wr_mid_rempty: got %b expected 1", r_empty); end
    idle(1);
    checks++; if (r_level !== exp_lvl(1)) begin errors++; $display("[TB] FAIL wr_cross_rlevel: got %0d expected %0d", r_level, exp_lvl(1)); end
    checks++; if (r_empty !== 1'b0) begin errors++; $display("[TB] FAIL wr_cross_rempty: got %b expected 0", r_empty); end
    checks++; if (r_data !== 16'h1234) begin errors++; $display("[TB] FAIL wr_rdata: got %h expected 1234", r_data); end
  endtask

  task automatic test_single_read();
    step(1'b0, 1'b0, 1'b1, '0);
    checks++; if (r_level !== exp_lvl(0)) begin errors++; $display("[TB] FAIL rd_own_rlevel: got %0d expected %0d", r_level, exp_lvl(0)); end
    checks++; if (r_empty !== 1'b1) begin errors++; $display("[TB] FAIL rd_own_rempty: got %b expected 1", r_empty); end
    checks++; if (w_level !== exp_lvl(1)) begin errors++; $display("[TB] FAIL rd_early_wlevel: got %0d expected %0d", w_level, exp_lvl(1)); end
    idle(2);
    checks++; if (w_level !== exp_lvl(0)) begin errors++; $display("[TB] FAIL rd_cross_wlevel: got %0d expected %0d", w_level, exp_lvl(0)); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, 1'b0, WI'($urandom));
    checks++; if (w_level !== exp_lvl(D)) begin errors++; $display("[TB] FAIL fill_wlevel: got %0d expected %0d", w_level, exp_lvl(D)); end
    checks++; if (w_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_wfull: got %b expected 1", w_full); end
    step(1'b0, 1'b1, 1'b0, 16'hDEAD);
    checks++; if (w_level !== exp_lvl(D)) begin errors++; $display("[TB] FAIL overflow_wlevel: got %0d expected %0d", w_level, exp_lvl(D)); end
    checks++; if (w_full !== 1'b1) begin errors++; $display("[TB] FAIL overflow_wfull: got %b expected 1", w_full); end
    idle(2);
    checks++; if (r_level !== exp_lvl(D)) begin errors++; $display("[TB] FAIL fill_rlevel: got %0d expected %0d", r_level, exp_lvl(D)); end
    for (int i = 0; i < D; i++) begin
      checks++; if (r_data !== q[0]) begin errors++; $display("[TB] FAIL drain_rdata[%0d]: got %h expected %h", i, r_data, q[0]); end
      step(1'b0, 1'b0, 1'b1, '0);
    end
    checks++; if (r_empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_rempty: got %b expected 1", r_empty); end
    idle(2);
    checks++; if (w_level !== exp_lvl(0)) begin errors++; $display("[TB] FAIL drain_wlevel: got %0d expected %0d", w_level, exp_lvl(0)); end
    checks++; if (w_full !== 1'b0) begin errors++; $display("[TB] FAIL drain_wfull: got %b expected 0", w_full); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, WI'($urandom));
    idle(3);
    step(1'b0, 1'b1, 1'b1, WI'($urandom));
    for (int c = 0; c < 3; c++) begin
      if (c > 0) idle(1);
      checks++; if (w_level !== exp_lvl(m_wl())) begin errors++; $display("[TB] FAIL b2b_wlevel[%0d]: got %0d expected %0d", c, w_level, exp_lvl(m_wl())); end
      checks++; if (r_level !== exp_lvl(m_rl())) begin errors++; $display("[TB] FAIL b2b_rlevel[%0d]: got %0d expected %0d", c, r_level, exp_lvl(m_rl())); end
      checks++; if (r_data !== q[0]) begin errors++; $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", c, r_data, q[0]); end
    end
    checks++; if (w_level !== exp_lvl(5)) begin errors++; $display("[TB] FAIL b2b_final_wlevel: got %0d expected %0d", w_level, exp_lvl(5)); end
    checks++; if (r_level !== exp_lvl(5)) begin errors++; $display("[TB] FAIL b2b_final_rlevel: got %0d expected %0d", r_level, exp_lvl(5)); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, i[0], WI'($urandom));
    step(1'b1, 1'b1, 1'b1, WI'($urandom));
    for (int c = 0; c < 4; c++) begin
      checks++; if (w_level !== exp_lvl(0) || r_level !== exp_lvl(0)) begin errors++; $display("[TB] FAIL midreset_levels[%0d]: got %0d/%0d expected 0/0", c, w_level, r_level); end
      checks++; if (w_full !== 1'b0 || r_empty !== 1'b1) begin errors++; $display("[TB] FAIL midreset_flags[%0d]: got full=%b empty=%b expected 0/1", c, w_full, r_empty); end
      idle(1);
    end
  endtask

  task automatic test_random();
    int pw;
    logic ws, rs;
    for (int it = 0; it < 3000; it++) begin
      case ((it / 150) % 3)
        0:       pw = 80;
        1:       pw = 50;
        default: pw = 20;
      endcase
      ws = ($urandom_range(99) < pw);
      rs = ($urandom_range(99) < (100 - pw));
      // One request cycle followed by four idle cycles, checked at every sample.
      for (int c = 0; c < 5; c++) begin
        if (c == 0) step(1'b0, ws, rs, WI'($urandom));
        else        idle(1);
        checks++; if (w_level !== exp_lvl(m_wl())) begin errors++; $display("[TB] FAIL rnd_wlevel it=%0d c=%0d: got %0d expected %0d", it, c, w_level, exp_lvl(m_wl())); end
        checks++; if (r_level !== exp_lvl(m_rl())) begin errors++; $display("[TB] FAIL rnd_rlevel it=%0d c=%0d: got %0d expected %0d", it, c, r_level, exp_lvl(m_rl())); end
        checks++; if (w_full !== (m_wl() == D)) begin errors++; $display("[TB] FAIL rnd_wfull it=%0d c=%0d: got %b expected %b", it, c, w_full, (m_wl() == D)); end
        checks++; if (r_empty !== (m_rl() == 0)) begin errors++; $display("[TB] FAIL rnd_rempty it=%0d c=%0d: got %b expected %b", it, c, r_empty, (m_rl() == 0)); end
        if (m_rl() > 0) begin
          checks++; if (r_data !== q[0]) begin errors++; $display("[TB] FAIL rnd_rdata it=%0d c=%0d: got %h expected %h", it, c, r_data, q[0]); end
        end
      end
    end
  endtask

  initial begin
    $display("[TB] async_fifo_1clk bench start");
    test_reset();
    test_single_write();
    test_single_read();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
